// File: rtl/freq_result_calc.sv
// Result stage for the equal-precision frequency counter: turns raw gate counts into Hz and
// per-mille ratios with one shared 64/32 restoring divider, and optionally re-arms the counter.
module freq_result_calc #(
    parameter int unsigned F_BASE       = 200_000_000,
    parameter int unsigned RATIO_SCALE  = 1000,
    parameter int unsigned AUTO_RESTART = 1,
    parameter int unsigned RESTART_GAP  = 1000
) (
    input  logic        fbase,
    input  logic        rst,
    input  logic        done_sig,
    input  logic [31:0] fxCnt,
    input  logic [31:0] fbaseCnt,
    input  logic [31:0] dutyCnt,
    input  logic [31:0] delayCnt,
    input  logic        meas_req,
    output logic        meas_start,
    output logic [31:0] freq_hz,
    output logic [15:0] duty_pm,
    output logic [15:0] delay_pm,
    output logic        res_valid,
    output logic        busy,
    output logic        div_err,
    output logic        sat_flag,
    output logic        overrun
);

    localparam logic [31:0] F_BASE_C      = F_BASE[31:0];
    localparam logic [31:0] RATIO_SCALE_C = RATIO_SCALE[31:0];
    localparam logic [31:0] GAP_C         = RESTART_GAP[31:0];
    localparam logic        AUTO_C        = (AUTO_RESTART != 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Saturate a 64-bit quotient into 32 bits; MSB of the result is the overflow flag.
    function automatic logic [32:0] sat32(input logic [63:0] q);
        logic [32:0] r;
        if (q[63:32] != 32'd0) begin
            r = {1'b1, 32'hFFFF_FFFF};
        end else begin
            r = {1'b0, q[31:0]};
        end
        return r;
    endfunction

    // Saturate a 64-bit quotient into 16 bits; MSB of the result is the overflow flag.
    function automatic logic [16:0] sat16(input logic [63:0] q);
        logic [16:0] r;
        if (q[63:16] != 48'd0) begin
            r = {1'b1, 16'hFFFF};
        end else begin
            r = {1'b0, q[15:0]};
        end
        return r;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;

    logic [31:0] cnt_fx_r;
    logic [31:0] cnt_fbase_r;
    logic [31:0] cnt_duty_r;
    logic [31:0] cnt_delay_r;

    logic [1:0]  pass_r;
    logic [5:0]  iter_r;
    logic [63:0] dvd_r;
    logic [31:0] rem_r;

    logic [31:0] q_freq_r;
    logic [15:0] q_duty_r;
    logic [15:0] q_delay_r;
    logic        sat_acc_r;
    logic        zero_div_r;

    logic [31:0] gap_cnt_r;
    logic        gap_active_r;

    logic        capture_s;
    logic        req_accept_s;
    logic [31:0] mul_a_s;
    logic [31:0] mul_b_s;
    logic [63:0] product_s;
    logic [32:0] trial_s;
    logic        q_bit_s;
    logic [31:0] rem_nxt_s;
    logic [63:0] quot_full_s;
    logic        div_last_s;
    logic [32:0] sat32_s;
    logic [16:0] sat16_s;

    assign capture_s    = (state_r == ST_IDLE) && done_sig;
    assign req_accept_s = (state_r == ST_IDLE) && meas_req;

    // Operand select and shared multiplier feeding the dividend for the current pass.
    always_comb begin
        mul_a_s = 32'd0;
        mul_b_s = 32'd0;
        case (pass_r)
            2'd0: begin
                mul_a_s = cnt_fx_r;
                mul_b_s = F_BASE_C;
            end
            2'd1: begin
                mul_a_s = cnt_duty_r;
                mul_b_s = RATIO_SCALE_C;
            end
            2'd2: begin
                mul_a_s = cnt_delay_r;
                mul_b_s = RATIO_SCALE_C;
            end
            default: begin
                mul_a_s = 32'd0;
                mul_b_s = 32'd0;
            end
        endcase
        product_s = 64'(mul_a_s) * 64'(mul_b_s);
    end

    // One restoring-division step; remainder stays below the divisor so 33 bits suffice.
    always_comb begin
        trial_s = {rem_r, dvd_r[63]} - {1'b0, cnt_fbase_r};
        q_bit_s = ~trial_s[32];
        if (q_bit_s) begin
            rem_nxt_s = trial_s[31:0];
        end else begin
            rem_nxt_s = {rem_r[30:0], dvd_r[63]};
        end
        quot_full_s = {dvd_r[62:0], q_bit_s};
        div_last_s  = (iter_r == 6'd63);
        sat32_s     = sat32(quot_full_s);
        sat16_s     = sat16(quot_full_s);
    end

    // Next-state logic for the capture / load / divide / output sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (done_sig) begin
                    if (fbaseCnt == 32'd0) begin
                        state_nxt_s = ST_OUT;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_DIV;
            end
            ST_DIV: begin
                if (div_last_s) begin
                    if (pass_r == 2'd2) begin
                        state_nxt_s = ST_OUT;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_OUT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge fbase or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Count latch, divider datapath and per-pass quotient storage.
    always_ff @(posedge fbase or posedge rst) begin
        if (rst) begin
            cnt_fx_r    <= 32'd0;
            cnt_fbase_r <= 32'd0;
            cnt_duty_r  <= 32'd0;
            cnt_delay_r <= 32'd0;
            pass_r      <= 2'd0;
            iter_r      <= 6'd0;
            dvd_r       <= 64'd0;
            rem_r       <= 32'd0;
            q_freq_r    <= 32'd0;
            q_duty_r    <= 16'd0;
            q_delay_r   <= 16'd0;
            sat_acc_r   <= 1'b0;
            zero_div_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (done_sig) begin
                        cnt_fx_r    <= fxCnt;
                        cnt_fbase_r <= fbaseCnt;
                        cnt_duty_r  <= dutyCnt;
                        cnt_delay_r <= delayCnt;
                        pass_r      <= 2'd0;
                        q_freq_r    <= 32'd0;
                        q_duty_r    <= 16'd0;
                        q_delay_r   <= 16'd0;
                        sat_acc_r   <= 1'b0;
                        zero_div_r  <= (fbaseCnt == 32'd0);
                    end
                end
                ST_LOAD: begin
                    dvd_r  <= product_s;
                    rem_r  <= 32'd0;
                    iter_r <= 6'd0;
                end
                ST_DIV: begin
                    dvd_r  <= quot_full_s;
                    rem_r  <= rem_nxt_s;
                    iter_r <= iter_r + 6'd1;
                    if (div_last_s) begin
                        pass_r <= pass_r + 2'd1;
                        case (pass_r)
                            2'd0: begin
                                q_freq_r  <= sat32_s[31:0];
                                sat_acc_r <= sat_acc_r | sat32_s[32];
                            end
                            2'd1: begin
                                q_duty_r  <= sat16_s[15:0];
                                sat_acc_r <= sat_acc_r | sat16_s[16];
                            end
                            2'd2: begin
                                q_delay_r <= sat16_s[15:0];
                                sat_acc_r <= sat_acc_r | sat16_s[16];
                            end
                            default: begin
                                sat_acc_r <= sat_acc_r;
                            end
                        endcase
                    end
                end
                ST_OUT: begin
                    pass_r <= 2'd0;
                end
                default: begin
                    pass_r <= 2'd0;
                end
            endcase
        end
    end

    // Result outputs, valid strobe, busy and sticky status flags.
    always_ff @(posedge fbase or posedge rst) begin
        if (rst) begin
            freq_hz   <= 32'd0;
            duty_pm   <= 16'd0;
            delay_pm  <= 16'd0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            div_err   <= 1'b0;
            sat_flag  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            res_valid <= (state_r == ST_OUT);
            if (capture_s) begin
                busy <= 1'b1;
            end else if (state_r == ST_OUT) begin
                busy <= 1'b0;
            end
            if (state_r == ST_OUT) begin
                freq_hz  <= q_freq_r;
                duty_pm  <= q_duty_r;
                delay_pm <= q_delay_r;
                div_err  <= div_err | zero_div_r;
                sat_flag <= sat_flag | sat_acc_r;
            end else if (req_accept_s) begin
                div_err  <= 1'b0;
                sat_flag <= 1'b0;
            end
            // A completion pulse outside IDLE (including the OUT cycle) is lost.
            if (done_sig && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end else if (req_accept_s) begin
                overrun <= 1'b0;
            end
        end
    end

    // Start pulse generation: manual request or automatic restart after the gap.
    always_ff @(posedge fbase or posedge rst) begin
        if (rst) begin
            meas_start   <= 1'b0;
            gap_cnt_r    <= 32'd0;
            gap_active_r <= 1'b0;
        end else begin
            if ((state_r == ST_OUT) && AUTO_C) begin
                meas_start   <= 1'b0;
                gap_cnt_r    <= GAP_C;
                gap_active_r <= 1'b1;
            end else if (req_accept_s) begin
                meas_start   <= 1'b1;
                gap_cnt_r    <= 32'd0;
                gap_active_r <= 1'b0;
            end else if (gap_active_r) begin
                if (gap_cnt_r <= 32'd1) begin
                    meas_start   <= 1'b1;
                    gap_cnt_r    <= 32'd0;
                    gap_active_r <= 1'b0;
                end else begin
                    meas_start <= 1'b0;
                    gap_cnt_r  <= gap_cnt_r - 32'd1;
                end
            end else begin
                meas_start <= 1'b0;
            end
        end
    end

endmodule
